// File: rtl/subcarrier_demapper_if.sv
// AXI-stream style bundle used on both sides of the subcarrier demapper.
// The input side ignores tuser; the output side carries the subcarrier index in it.
interface subcarrier_demapper_if #(
    parameter int DATA_W = 64,
    parameter int USER_W = 10
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [USER_W-1:0] tuser;

    // A beat transfers on a rising clock edge where tvalid and tready are both high;
    // the master holds tdata/tlast/tuser stable while tvalid is high and tready is low.
    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/subcarrier_demapper.sv
// OFDM subcarrier demapper: tracks the bin index of each FFT symbol, keeps two configurable
// bands, rescales I/Q with saturation and reports sync errors and statistics.
module subcarrier_demapper #(
    parameter int LOG2_NFFT = 10,
    parameter int IN_W      = 32,
    parameter int OUT_W     = 16,
    parameter int SHIFT_W   = 5
) (
    input  logic                 s00_axis_aclk,
    input  logic                 s00_axis_areset,
    subcarrier_demapper_if.slave  s00_axis,
    subcarrier_demapper_if.master m00_axis,
    input  logic [LOG2_NFFT-1:0] cfg_lo_start,
    input  logic [LOG2_NFFT-1:0] cfg_lo_end,
    input  logic [LOG2_NFFT-1:0] cfg_hi_start,
    input  logic [LOG2_NFFT-1:0] cfg_hi_end,
    input  logic [SHIFT_W-1:0]   cfg_shift,
    input  logic                 stat_clear,
    output logic [31:0]          stat_sym_count,
    output logic                 stat_sync_err,
    output logic                 stat_sat
);
    localparam logic [LOG2_NFFT-1:0] IDX_LAST = '1;
    localparam logic signed [IN_W-1:0] SAT_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] SAT_MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Returns {clipped, value}; a shift at or beyond IN_W leaves only the sign fill.
    function automatic logic [OUT_W:0] scale(input logic [IN_W-1:0] x, input logic [SHIFT_W-1:0] sh);
        logic signed [IN_W-1:0] y;
        y = $signed(x) >>> sh;
        if (y > SAT_MAX)      scale = {1'b1, SAT_MAX[OUT_W-1:0]};
        else if (y < SAT_MIN) scale = {1'b1, SAT_MIN[OUT_W-1:0]};
        else                  scale = {1'b0, y[OUT_W-1:0]};
    endfunction

    logic [LOG2_NFFT-1:0] r_idx;
    logic [LOG2_NFFT-1:0] r_sh_lo_s, r_sh_lo_e, r_sh_hi_s, r_sh_hi_e;
    logic [SHIFT_W-1:0]   r_sh_shift;
    logic                 r_valid, r_last;
    logic [OUT_W-1:0]     r_i, r_q;
    logic [LOG2_NFFT-1:0] r_user;
    logic [31:0]          r_sym_cnt;
    logic                 r_sync_err, r_sat;

    logic                 w_acc, w_first, w_at_last, w_keep, w_clip;
    logic [LOG2_NFFT-1:0] w_lo_s, w_lo_e, w_hi_s, w_hi_e;
    logic [SHIFT_W-1:0]   w_shift;
    logic [OUT_W:0]       w_si, w_sq;

    assign s00_axis.tready = ~r_valid | m00_axis.tready;
    assign w_acc     = s00_axis.tvalid & s00_axis.tready;
    assign w_first   = (r_idx == '0);
    assign w_at_last = (r_idx == IDX_LAST);

    // The first bin of a symbol is judged with the live config, later bins with the snapshot.
    assign w_lo_s  = w_first ? cfg_lo_start : r_sh_lo_s;
    assign w_lo_e  = w_first ? cfg_lo_end   : r_sh_lo_e;
    assign w_hi_s  = w_first ? cfg_hi_start : r_sh_hi_s;
    assign w_hi_e  = w_first ? cfg_hi_end   : r_sh_hi_e;
    assign w_shift = w_first ? cfg_shift    : r_sh_shift;

    assign w_keep = ((w_lo_s <= r_idx) && (r_idx <= w_lo_e)) ||
                    ((w_hi_s <= r_idx) && (r_idx <= w_hi_e));
    assign w_si   = scale(s00_axis.tdata[IN_W-1:0], w_shift);
    assign w_sq   = scale(s00_axis.tdata[2*IN_W-1:IN_W], w_shift);
    assign w_clip = w_si[OUT_W] | w_sq[OUT_W];

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            r_idx      <= '0;
            r_sh_lo_s  <= LOG2_NFFT'(1);
            r_sh_lo_e  <= LOG2_NFFT'(400);
            r_sh_hi_s  <= LOG2_NFFT'(623);
            r_sh_hi_e  <= LOG2_NFFT'(1022);
            r_sh_shift <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_i        <= '0;
            r_q        <= '0;
            r_user     <= '0;
            r_sym_cnt  <= '0;
            r_sync_err <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            if (w_acc) begin
                r_idx <= (s00_axis.tlast || w_at_last) ? '0 : r_idx + 1'b1;
                if (w_first) begin
                    r_sh_lo_s  <= cfg_lo_start;
                    r_sh_lo_e  <= cfg_lo_end;
                    r_sh_hi_s  <= cfg_hi_start;
                    r_sh_hi_e  <= cfg_hi_end;
                    r_sh_shift <= cfg_shift;
                end
            end

            if (w_acc && w_keep) begin
                r_valid <= 1'b1;
                r_i     <= w_si[OUT_W-1:0];
                r_q     <= w_sq[OUT_W-1:0];
                r_last  <= (r_idx == w_hi_e);
                r_user  <= r_idx;
            end else if (m00_axis.tready) begin
                r_valid <= 1'b0;
            end

            // A clear in the same cycle as an event discards the event.
            if (stat_clear) begin
                r_sym_cnt  <= '0;
                r_sync_err <= 1'b0;
                r_sat      <= 1'b0;
            end else if (w_acc) begin
                if (w_at_last || s00_axis.tlast) r_sym_cnt <= r_sym_cnt + 32'd1;
                if (s00_axis.tlast != w_at_last) r_sync_err <= 1'b1;
                if (w_keep && w_clip)            r_sat <= 1'b1;
            end
        end
    end

    assign m00_axis.tvalid = r_valid;
    assign m00_axis.tdata  = {r_q, r_i};
    assign m00_axis.tlast  = r_last;
    assign m00_axis.tuser  = r_user;
    assign stat_sym_count  = r_sym_cnt;
    assign stat_sync_err   = r_sync_err;
    assign stat_sat        = r_sat;
endmodule

// File: tb/tb_subcarrier_demapper.sv
// Bench for subcarrier_demapper: reference model feeding an expected-beat queue,
// a table of scaling vectors and directed multi-cycle sequences.
module tb_subcarrier_demapper;
  localparam int LOG2_NFFT = 10;
  localparam int IN_W      = 32;
  localparam int OUT_W     = 16;
  localparam int SHIFT_W   = 5;
  localparam int NFFT      = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  subcarrier_demapper_if #(.DATA_W(2*IN_W),  .USER_W(LOG2_NFFT)) s_if ();
  subcarrier_demapper_if #(.DATA_W(2*OUT_W), .USER_W(LOG2_NFFT)) m_if ();

  logic [LOG2_NFFT-1:0] cfg_lo_start, cfg_lo_end, cfg_hi_start, cfg_hi_end;
  logic [SHIFT_W-1:0]   cfg_shift;
  logic                 stat_clear;
  logic [31:0]          stat_sym_count;
  logic                 stat_sync_err, stat_sat;

  subcarrier_demapper #(
    .LOG2_NFFT(LOG2_NFFT), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .s00_axis_aclk  (clk),
    .s00_axis_areset(rst),
    .s00_axis       (s_if),
    .m00_axis       (m_if),
    .cfg_lo_start   (cfg_lo_start),
    .cfg_lo_end     (cfg_lo_end),
    .cfg_hi_start   (cfg_hi_start),
    .cfg_hi_end     (cfg_hi_end),
    .cfg_shift      (cfg_shift),
    .stat_clear     (stat_clear),
    .stat_sym_count (stat_sym_count),
    .stat_sync_err  (stat_sync_err),
    .stat_sat       (stat_sat)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [42:0] exp_q[$];
  int out_cnt = 0;
  int last_cnt = 0;
  logic [31:0] tbl_out;
  logic [9:0]  last_user;
  int ready_mode = 1;  // 0 = hold low, 1 = hold high, 2 = random

  int m_idx;
  int sh_lo_s, sh_lo_e, sh_hi_s, sh_hi_e, sh_shift;
  logic [31:0] exp_sym;
  logic exp_err, exp_sat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] model_scale(input logic [31:0] x, input int sh);
    longint v;
    v = longint'($signed(x)) >>> sh;
    if (v > 32767)  return {1'b1, 16'h7FFF};
    if (v < -32768) return {1'b1, 16'h8000};
    return {1'b0, v[15:0]};
  endfunction

  task automatic model_reset();
    m_idx = 0;
    sh_lo_s = 1; sh_lo_e = 400; sh_hi_s = 623; sh_hi_e = 1022; sh_shift = 0;
    exp_sym = 0; exp_err = 1'b0; exp_sat = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [63:0] d, input logic last);
    logic [16:0] ri, rq;
    bit keep;
    if (m_idx == 0) begin
      sh_lo_s = int'(cfg_lo_start); sh_lo_e = int'(cfg_lo_end);
      sh_hi_s = int'(cfg_hi_start); sh_hi_e = int'(cfg_hi_end);
      sh_shift = int'(cfg_shift);
    end
    keep = (m_idx >= sh_lo_s && m_idx <= sh_lo_e) || (m_idx >= sh_hi_s && m_idx <= sh_hi_e);
    ri = model_scale(d[31:0], sh_shift);
    rq = model_scale(d[63:32], sh_shift);
    if (keep) begin
      exp_q.push_back({10'(m_idx), (m_idx == sh_hi_e), rq[15:0], ri[15:0]});
      if (ri[16] || rq[16]) exp_sat = 1'b1;
    end
    if (last != (m_idx == NFFT-1)) exp_err = 1'b1;
    if (last || m_idx == NFFT-1) exp_sym = exp_sym + 32'd1;
    m_idx = (last || m_idx == NFFT-1) ? 0 : m_idx + 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [63:0] d, input logic last);
    int n = 0;
    s_if.tdata = d; s_if.tlast = last; s_if.tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_if.tready) break;
      n++;
      if (n > 2000) begin
        checks++; errors++;
        $display("FAIL input_timeout: tready stuck low, got 0 expected 1");
        break;
      end
    end
    if (n <= 2000) model_accept(d, last);
    @(posedge clk); #1;
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
  endtask

  task automatic send_symbol(input int n_beats, input int last_at, input bit rnd);
    for (int i = 0; i < n_beats; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send_beat(rnd ? {$urandom, $urandom} : {32'(i), 32'(i)}, i == last_at);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin @(posedge clk); n++; end
    check("drain_queue_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_sym_count"}, stat_sym_count, exp_sym);
    check({tag, "_sync_err"}, stat_sync_err, exp_err);
    check({tag, "_sat"}, stat_sat, exp_sat);
  endtask

  task automatic pulse_clear();
    stat_clear = 1'b1;
    @(posedge clk); #1;
    stat_clear = 1'b0;
    exp_sym = 0; exp_err = 1'b0; exp_sat = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- output ready and monitor ----------------
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk); #2;
      m_if.tready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end
  end

  initial begin
    logic [42:0] got, prev_beat;
    logic prev_stall;
    prev_stall = 1'b0;
    prev_beat = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        got = {m_if.tuser, m_if.tlast, m_if.tdata};
        if (prev_stall) check("stall_hold", {m_if.tvalid, got}, {1'b1, prev_beat});
        if (m_if.tvalid && m_if.tready) begin
          out_cnt++;
          if (m_if.tlast) last_cnt++;
          if (m_if.tuser == 10'd1) tbl_out = m_if.tdata;
          last_user = m_if.tuser;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL out_beat: unexpected beat %h, expected none", got);
          end else begin
            check("out_beat", got, exp_q.pop_front());
          end
        end
        prev_stall = m_if.tvalid && !m_if.tready;
        prev_beat = got;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0]  shift;
    logic [31:0] i_in;
    logic [31:0] q_in;
    logic [15:0] i_exp;
    logic [15:0] q_exp;
    logic        sat_exp;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int o0, l0;
    vecs[0] = '{5'd0,  32'h0001_0000, 32'hFFFE_0000, 16'h7FFF, 16'h8000, 1'b1};
    vecs[1] = '{5'd16, 32'h0001_0000, 32'hFFFE_0000, 16'h0001, 16'hFFFE, 1'b0};
    vecs[2] = '{5'd0,  32'h0000_1234, 32'hFFFF_FFFF, 16'h1234, 16'hFFFF, 1'b0};
    vecs[3] = '{5'd4,  32'h0007_FFF0, 32'hFFF8_0000, 16'h7FFF, 16'h8000, 1'b0};
    vecs[4] = '{5'd31, 32'h8000_0000, 32'h7FFF_FFFF, 16'hFFFF, 16'h0000, 1'b0};
    vecs[5] = '{5'd8,  32'h0080_0000, 32'hFF7F_FF00, 16'h7FFF, 16'h8000, 1'b1};

    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = '0;
    cfg_lo_start = 10'd1; cfg_lo_end = 10'd400; cfg_hi_start = 10'd623; cfg_hi_end = 10'd1022;
    cfg_shift = '0; stat_clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk); #1;
    do_reset();

    check("reset_tvalid", m_if.tvalid, 0);
    check("reset_tdata", m_if.tdata, 0);
    check("reset_tlast", m_if.tlast, 0);
    check("reset_tuser", m_if.tuser, 0);
    check("reset_sym_count", stat_sym_count, 0);
    check("reset_sync_err", stat_sync_err, 0);
    check("reset_sat", stat_sat, 0);
    check("reset_s_tready", s_if.tready, 1);

    // default bands, no back-pressure, data = index
    o0 = out_cnt; l0 = last_cnt;
    send_symbol(NFFT, NFFT-1, 0);
    drain();
    check("sym1_out_count", out_cnt - o0, 800);
    check("sym1_tlast_count", last_cnt - l0, 1);
    check("sym1_sym_count", stat_sym_count, 1);
    check_stats("sym1");

    // random back-pressure and input gaps over three symbols
    ready_mode = 2;
    o0 = out_cnt;
    for (int s = 0; s < 3; s++) send_symbol(NFFT, NFFT-1, 1);
    ready_mode = 1;
    drain();
    check("bp_out_count", out_cnt - o0, 2400);
    check_stats("bp");

    // scaling / saturation table, vector placed at kept index 1
    for (int v = 0; v < 6; v++) begin
      pulse_clear();
      cfg_shift = vecs[v].shift;
      for (int i = 0; i < NFFT; i++)
        send_beat((i == 1) ? {vecs[v].q_in, vecs[v].i_in} : 64'd0, i == NFFT-1);
      drain();
      check($sformatf("vec%0d_data", v), tbl_out, {vecs[v].q_exp, vecs[v].i_exp});
      check($sformatf("vec%0d_sat", v), stat_sat, vecs[v].sat_exp);
    end
    cfg_shift = '0;

    // early tlast at index 500, then a clean symbol
    pulse_clear();
    send_symbol(501, 500, 0);
    drain();
    check("resync_err", stat_sync_err, 1);
    o0 = out_cnt; l0 = last_cnt;
    send_symbol(NFFT, NFFT-1, 0);
    drain();
    check("resync_next_out_count", out_cnt - o0, 800);
    check("resync_next_tlast", last_cnt - l0, 1);
    check_stats("resync");

    // mid-symbol band change applies from the next symbol
    o0 = out_cnt;
    for (int i = 0; i < NFFT; i++) begin
      if (i == 300) cfg_lo_end = 10'd200;
      send_beat({32'(i), 32'(i)}, i == NFFT-1);
    end
    drain();
    check("cfgchg_cur_count", out_cnt - o0, 800);
    o0 = out_cnt;
    send_symbol(NFFT, NFFT-1, 0);
    drain();
    check("cfgchg_next_count", out_cnt - o0, 600);
    check_stats("cfgchg");

    // reset mid-symbol while an output beat is stalled
    cfg_lo_end = 10'd800;
    send_symbol(701, -1, 0);
    ready_mode = 0;
    @(posedge clk); #1;
    check("prereset_tvalid", m_if.tvalid, 1);
    check("prereset_tuser", m_if.tuser, 700);
    do_reset();
    check("midreset_tvalid", m_if.tvalid, 0);
    check("midreset_sym_count", stat_sym_count, 0);
    check("midreset_sync_err", stat_sync_err, 0);
    check("midreset_sat", stat_sat, 0);
    cfg_lo_end = 10'd400;
    cfg_lo_start = 10'd0;
    ready_mode = 1;
    send_beat(64'h0000_0005_0000_0007, 1'b0);
    drain();
    check("postreset_first_idx", last_user, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
